// File: rtl/ex_div_if.sv
`default_nettype none
// ============================================================================
//  Module      : ex_div_if
//  Description : Divider request/result bundle between the EX stage and ex_div.
//  Revision    : 1.0  initial release
// ============================================================================
interface ex_div_if #(
    parameter int WIDTH = 32
);
    logic                 div_start;
    logic                 signed_div;
    logic [WIDTH-1:0]     opdata1;
    logic [WIDTH-1:0]     opdata2;
    logic                 annul;
    logic [2*WIDTH-1:0]   result;
    logic                 ready;
    logic                 stallreq_for_div;

    // EX stage side
    modport master (
        output div_start, signed_div, opdata1, opdata2, annul,
        input  result, ready, stallreq_for_div
    );

    // Divider side
    modport slave (
        input  div_start, signed_div, opdata1, opdata2, annul,
        output result, ready, stallreq_for_div
    );
endinterface
`default_nettype wire

// File: rtl/ex_div.sv
`default_nettype none
// ============================================================================
//  Module      : ex_div
//  Description : Multi-cycle radix-2 restoring divider for the EX stage,
//                stalling the pipeline while a divide is in flight.
//  Revision    : 1.0  initial release
// ============================================================================
module ex_div #(
    parameter int WIDTH = 32
) (
    input  wire logic  clk,
    input  wire logic  rst,
    ex_div_if.slave    bus
);
    localparam int              CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_DIV_ZERO = 2'd1,
        S_BUSY     = 2'd2,
        S_DONE     = 2'd3
    } state_t;

    state_t               state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [WIDTH-1:0]     rem_q;
    logic [WIDTH-1:0]     dvd_q;
    logic [WIDTH-1:0]     dvs_q;
    logic                 negq_q;
    logic                 negr_q;
    logic [2*WIDTH-1:0]   result_q;
    logic                 ready_q;

    logic [WIDTH:0]       trial_d;
    logic [WIDTH:0]       sub_d;
    logic                 qbit_d;
    logic [WIDTH-1:0]     rem_d;
    logic [WIDTH-1:0]     quo_d;
    logic [WIDTH-1:0]     rem_fin_d;
    logic [WIDTH-1:0]     quo_fin_d;
    logic [WIDTH-1:0]     abs1_d;
    logic [WIDTH-1:0]     abs2_d;

    // One restoring step: a borrow-free subtraction means the quotient bit is 1.
    always_comb begin
        trial_d   = {rem_q, dvd_q[WIDTH-1]};
        sub_d     = trial_d - {1'b0, dvs_q};
        qbit_d    = ~sub_d[WIDTH];
        rem_d     = qbit_d ? sub_d[WIDTH-1:0] : trial_d[WIDTH-1:0];
        quo_d     = {dvd_q[WIDTH-2:0], qbit_d};
        quo_fin_d = negq_q ? (~quo_d + 1'b1) : quo_d;
        rem_fin_d = negr_q ? (~rem_d + 1'b1) : rem_d;
        abs1_d    = (bus.signed_div && bus.opdata1[WIDTH-1]) ? (~bus.opdata1 + 1'b1) : bus.opdata1;
        abs2_d    = (bus.signed_div && bus.opdata2[WIDTH-1]) ? (~bus.opdata2 + 1'b1) : bus.opdata2;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            rem_q    <= '0;
            dvd_q    <= '0;
            dvs_q    <= '0;
            negq_q   <= 1'b0;
            negr_q   <= 1'b0;
            result_q <= '0;
            ready_q  <= 1'b0;
        end else begin
            ready_q <= 1'b0;
            if (bus.annul) begin
                state_q <= S_IDLE;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (bus.div_start) begin
                            if (bus.opdata2 == '0) begin
                                state_q <= S_DIV_ZERO;
                                dvd_q   <= bus.opdata1;
                            end else begin
                                state_q <= S_BUSY;
                                dvd_q   <= abs1_d;
                                dvs_q   <= abs2_d;
                                negq_q  <= bus.signed_div & (bus.opdata1[WIDTH-1] ^ bus.opdata2[WIDTH-1]);
                                negr_q  <= bus.signed_div & bus.opdata1[WIDTH-1];
                                rem_q   <= '0;
                                cnt_q   <= '0;
                            end
                        end
                    end
                    S_DIV_ZERO: begin
                        state_q  <= S_DONE;
                        result_q <= {dvd_q, {WIDTH{1'b1}}};
                        ready_q  <= 1'b1;
                    end
                    S_BUSY: begin
                        rem_q <= rem_d;
                        dvd_q <= quo_d;
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == CNT_LAST) begin
                            state_q  <= S_DONE;
                            result_q <= {rem_fin_d, quo_fin_d};
                            ready_q  <= 1'b1;
                        end
                    end
                    S_DONE: begin
                        state_q <= S_IDLE;
                    end
                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.result           = result_q;
    assign bus.ready            = ready_q;
    // Combinational so the stall rises in the same cycle EX presents the divide.
    assign bus.stallreq_for_div = ~rst & bus.div_start & ~bus.annul & (state_q != S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_ex_div.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ex_div
//  Description : Directed self-checking bench for ex_div.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ex_div;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   cyc_cnt = 0;

    ex_div_if #(.WIDTH(32)) bus ();
    ex_div #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Drives one divide from the current cycle (cycle 0) until ready, then releases it.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                          output int start_c, output int ready_c, output bit stall_ok,
                          output logic stall_at_done, output logic [63:0] res);
        bus.div_start  = 1'b1;
        bus.signed_div = sgn;
        bus.opdata1    = a;
        bus.opdata2    = b;
        start_c        = cyc_cnt;
        ready_c        = -1;
        stall_ok       = 1'b1;
        stall_at_done  = 1'bx;
        res            = 'x;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.ready === 1'b1) begin
                ready_c       = cyc_cnt;
                res           = bus.result;
                stall_at_done = bus.stallreq_for_div;
                break;
            end
            if (bus.stallreq_for_div !== 1'b1) stall_ok = 1'b0;
        end
        @(posedge clk);
        #1;
        bus.div_start = 1'b0;
    endtask

    task automatic test_reset();
        bus.div_start = 1'b1;
        #1;
        checks++;
        if (bus.stallreq_for_div !== 1'b0) begin
            errors++; $display("FAIL reset_stall actual=%b required=0", bus.stallreq_for_div);
        end
        checks++;
        if (bus.ready !== 1'b0) begin
            errors++; $display("FAIL reset_ready actual=%b required=0", bus.ready);
        end
        checks++;
        if (bus.result !== 64'd0) begin
            errors++; $display("FAIL reset_result actual=%h required=0", bus.result);
        end
        bus.div_start = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_unsigned();
        int s, r; bit sok; logic sd; logic [63:0] res;
        run_op(32'd100, 32'd7, 1'b0, s, r, sok, sd, res);
        checks++;
        if (r - s !== 33) begin
            errors++; $display("FAIL u100_7_latency actual=%0d required=33", r - s);
        end
        checks++;
        if (res !== {32'd2, 32'd14}) begin
            errors++; $display("FAIL u100_7_result actual=%h required=%h", res, {32'd2, 32'd14});
        end
        checks++;
        if (!sok || sd !== 1'b0) begin
            errors++; $display("FAIL u100_7_stall actual=held:%0b done:%b required=held:1 done:0", sok, sd);
        end
    endtask

    task automatic test_signed();
        int s, r; bit sok; logic sd; logic [63:0] res;
        run_op(32'hFFFF_FFF9, 32'd2, 1'b1, s, r, sok, sd, res);
        checks++;
        if (r - s !== 33) begin
            errors++; $display("FAIL s_m7_2_latency actual=%0d required=33", r - s);
        end
        checks++;
        if (res !== 64'hFFFF_FFFF_FFFF_FFFD) begin
            errors++; $display("FAIL s_m7_2_result actual=%h required=ffffffff_fffffffd", res);
        end
        run_op(32'hFFFF_FFF9, 32'd2, 1'b0, s, r, sok, sd, res);
        checks++;
        if (res !== 64'h0000_0001_7FFF_FFFC) begin
            errors++; $display("FAIL u_m7_2_result actual=%h required=00000001_7ffffffc", res);
        end
    endtask

    task automatic test_div_zero();
        int s, r; bit sok; logic sd; logic [63:0] res;
        run_op(32'h1234, 32'd0, 1'b1, s, r, sok, sd, res);
        checks++;
        if (r - s !== 2) begin
            errors++; $display("FAIL div0_latency actual=%0d required=2", r - s);
        end
        checks++;
        if (res !== 64'h0000_1234_FFFF_FFFF) begin
            errors++; $display("FAIL div0_result actual=%h required=00001234_ffffffff", res);
        end
        checks++;
        if (!sok || sd !== 1'b0) begin
            errors++; $display("FAIL div0_stall actual=held:%0b done:%b required=held:1 done:0", sok, sd);
        end
    endtask

    task automatic test_overflow();
        int s, r; bit sok; logic sd; logic [63:0] res;
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, s, r, sok, sd, res);
        checks++;
        if (res !== 64'h0000_0000_8000_0000 || r - s !== 33) begin
            errors++; $display("FAIL overflow actual=%h lat=%0d required=00000000_80000000 lat=33", res, r - s);
        end
    endtask

    task automatic test_annul();
        bit seen_ready = 1'b0;
        bus.div_start  = 1'b1;
        bus.signed_div = 1'b0;
        bus.opdata1    = 32'd100;
        bus.opdata2    = 32'd7;
        repeat (10) @(posedge clk);
        #1;
        bus.annul = 1'b1;
        #1;
        checks++;
        if (bus.stallreq_for_div !== 1'b0) begin
            errors++; $display("FAIL annul_stall actual=%b required=0", bus.stallreq_for_div);
        end
        @(posedge clk);
        #1;
        bus.annul     = 1'b0;
        bus.div_start = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.ready !== 1'b0) seen_ready = 1'b1;
        end
        checks++;
        if (seen_ready) begin
            errors++; $display("FAIL annul_ready actual=pulse required=none");
        end
        checks++;
        if (bus.result !== 64'h0000_0000_8000_0000) begin
            errors++; $display("FAIL annul_result actual=%h required=00000000_80000000", bus.result);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        int s1, r1, s2, r2; bit sok; logic sd; logic [63:0] res1, res2;
        run_op(32'd9, 32'd3, 1'b0, s1, r1, sok, sd, res1);
        run_op(32'd10, 32'd4, 1'b0, s2, r2, sok, sd, res2);
        checks++;
        if (res1 !== {32'd0, 32'd3} || r1 - s1 !== 33) begin
            errors++; $display("FAIL b2b_first actual=%h lat=%0d required=%h lat=33", res1, r1 - s1, {32'd0, 32'd3});
        end
        checks++;
        if (s2 - s1 !== 34) begin
            errors++; $display("FAIL b2b_second_start actual=%0d required=34", s2 - s1);
        end
        checks++;
        if (r2 - s1 !== 67) begin
            errors++; $display("FAIL b2b_second_ready actual=%0d required=67", r2 - s1);
        end
        checks++;
        if (res2 !== {32'd2, 32'd2}) begin
            errors++; $display("FAIL b2b_second_result actual=%h required=%h", res2, {32'd2, 32'd2});
        end
    endtask

    task automatic test_reset_mid();
        bit seen_ready = 1'b0;
        bus.div_start  = 1'b1;
        bus.signed_div = 1'b0;
        bus.opdata1    = 32'h55;
        bus.opdata2    = 32'd5;
        repeat (20) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (bus.stallreq_for_div !== 1'b0) begin
            errors++; $display("FAIL rstmid_stall actual=%b required=0", bus.stallreq_for_div);
        end
        @(posedge clk);
        #1;
        rst           = 1'b0;
        bus.div_start = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.result !== 64'd0 || bus.ready !== 1'b0 || bus.stallreq_for_div !== 1'b0) begin
            errors++; $display("FAIL rstmid_outputs actual=%h/%b/%b required=0/0/0",
                               bus.result, bus.ready, bus.stallreq_for_div);
        end
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.ready !== 1'b0) seen_ready = 1'b1;
        end
        checks++;
        if (seen_ready) begin
            errors++; $display("FAIL rstmid_ready actual=pulse required=none");
        end
    endtask

    initial begin
        bus.div_start  = 1'b0;
        bus.signed_div = 1'b0;
        bus.opdata1    = '0;
        bus.opdata2    = '0;
        bus.annul      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        test_unsigned();
        test_signed();
        test_div_zero();
        test_overflow();
        test_annul();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
